// File: rtl/bpu.sv
// bpu: branch prediction unit for the fetch stage's speculative PC path.
// A direct-mapped BTB with 2-bit saturating counters gives a same-cycle
// taken prediction and target for the fetch PC. Branch resolutions from
// execute are checked for misprediction in the same cycle, which drives a
// redirect, and the table is trained at the following rising edge.
// Optional feature macro: BPU_STATS_EN adds resolved-branch and
// misprediction counters (branch_count_out, mispredict_count_out).
module bpu #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] pc_fetch_in,
    output logic             prediction_out,
    output logic [WIDTH-1:0] pc_prediction_out,
    input  logic             resolve_valid_in,
    input  logic [WIDTH-1:0] resolve_pc_in,
    input  logic             resolve_taken_in,
    input  logic [WIDTH-1:0] resolve_target_in,
    input  logic             resolve_pred_in,
    input  logic [WIDTH-1:0] resolve_pred_target_in,
    output logic             flush_out,
`ifdef BPU_STATS_EN
    output logic [WIDTH-1:0] pc_branch_out,
    output logic [31:0]      branch_count_out,
    output logic [31:0]      mispredict_count_out
`else
    output logic [WIDTH-1:0] pc_branch_out
`endif
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = WIDTH - IDX - 2;

    // BTB storage, one element per entry
    logic             valid_q  [ENTRIES];
    logic [TAGW-1:0]  tag_q    [ENTRIES];
    logic [WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];

    // Fetch-side lookup fields
    logic [IDX-1:0]   f_idx;
    logic [TAGW-1:0]  f_tag;
    logic             f_hit;

    // Resolve-side training fields
    logic [IDX-1:0]   r_idx;
    logic [TAGW-1:0]  r_tag;
    logic             r_hit;
    logic             mispredict;

    // Next-state for the single entry written at the resolving edge
    logic             wr_en_d;
    logic [1:0]       cnt_d;
    logic [WIDTH-1:0] target_d;

    // The byte offset bits of the fetch PC never take part in the lookup
    logic             unused_pc_bits;
    assign unused_pc_bits = ^pc_fetch_in[1:0];

    assign f_idx = pc_fetch_in[IDX+1:2];
    assign f_tag = pc_fetch_in[WIDTH-1:IDX+2];
    assign r_idx = resolve_pc_in[IDX+1:2];
    assign r_tag = resolve_pc_in[WIDTH-1:IDX+2];

    // Combinational lookup; outputs are forced low while reset is asserted
    always_comb begin
        f_hit             = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        prediction_out    = rst_in && f_hit && cnt_q[f_idx][1];
        pc_prediction_out = prediction_out ? target_q[f_idx] : '0;
    end

    // Misprediction detection and corrected PC for the fetch redirect mux
    always_comb begin
        mispredict = resolve_valid_in &&
                     ((resolve_taken_in != resolve_pred_in) ||
                      (resolve_taken_in && resolve_pred_in &&
                       (resolve_target_in != resolve_pred_target_in)));
        flush_out  = rst_in && mispredict;
        if (flush_out) begin
            pc_branch_out = resolve_taken_in ? resolve_target_in
                                             : resolve_pc_in + WIDTH'(4);
        end else begin
            pc_branch_out = '0;
        end
    end

    // Training decision: update a hit in place, allocate only on a taken miss
    always_comb begin
        r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        wr_en_d  = 1'b0;
        cnt_d    = cnt_q[r_idx];
        target_d = target_q[r_idx];
        if (resolve_valid_in) begin
            if (r_hit) begin
                wr_en_d = 1'b1;
                if (resolve_taken_in) begin
                    cnt_d    = (cnt_q[r_idx] == 2'b11) ? 2'b11 : cnt_q[r_idx] + 2'd1;
                    target_d = resolve_target_in;
                end else begin
                    cnt_d    = (cnt_q[r_idx] == 2'b00) ? 2'b00 : cnt_q[r_idx] - 2'd1;
                end
            end else if (resolve_taken_in) begin
                wr_en_d  = 1'b1;
                cnt_d    = 2'b10;
                target_d = resolve_target_in;
            end
        end
    end

    // Table state: async clear to weakly-not-taken, single-entry write per edge
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else if (wr_en_d) begin
            valid_q[r_idx]  <= 1'b1;
            tag_q[r_idx]    <= r_tag;
            target_q[r_idx] <= target_d;
            cnt_q[r_idx]    <= cnt_d;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] branch_count_q,     branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Statistics next-state; both counters wrap naturally at 2^32
    always_comb begin
        branch_count_d     = branch_count_q + (resolve_valid_in ? 32'd1 : 32'd0);
        mispredict_count_d = mispredict_count_q + (flush_out ? 32'd1 : 32'd0);
    end

    // Statistics registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count_out     = branch_count_q;
    assign mispredict_count_out = mispredict_count_q;
`endif

endmodule

// File: tb/tb_bpu.sv
// tb_bpu: directed, table-driven bench for the bpu branch predictor.
module tb_bpu;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] pc_fetch_in;
    logic        prediction_out;
    logic [31:0] pc_prediction_out;
    logic        resolve_valid_in;
    logic [31:0] resolve_pc_in;
    logic        resolve_taken_in;
    logic [31:0] resolve_target_in;
    logic        resolve_pred_in;
    logic [31:0] resolve_pred_target_in;
    logic        flush_out;
    logic [31:0] pc_branch_out;
`ifdef BPU_STATS_EN
    logic [31:0] branch_count_out;
    logic [31:0] mispredict_count_out;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int exp_branches = 0;
    int exp_flushes = 0;

    bpu #(.WIDTH(32), .ENTRIES(16)) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .pc_fetch_in            (pc_fetch_in),
        .prediction_out         (prediction_out),
        .pc_prediction_out      (pc_prediction_out),
        .resolve_valid_in       (resolve_valid_in),
        .resolve_pc_in          (resolve_pc_in),
        .resolve_taken_in       (resolve_taken_in),
        .resolve_target_in      (resolve_target_in),
        .resolve_pred_in        (resolve_pred_in),
        .resolve_pred_target_in (resolve_pred_target_in),
        .flush_out              (flush_out),
`ifdef BPU_STATS_EN
        .pc_branch_out          (pc_branch_out),
        .branch_count_out       (branch_count_out),
        .mispredict_count_out   (mispredict_count_out)
`else
        .pc_branch_out          (pc_branch_out)
`endif
    );

    // Clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rtaken;
        logic [31:0] rtgt;
        logic        rpred;
        logic [31:0] rptgt;
        logic [31:0] fpc;
        logic        eflush;
        logic [31:0] ebranch;
        logic        epred;
        logic [31:0] eptgt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_resolve(input logic rv, input logic [31:0] rpc, input logic rtaken,
                                 input logic [31:0] rtgt, input logic rpred,
                                 input logic [31:0] rptgt);
        resolve_valid_in       = rv;
        resolve_pc_in          = rpc;
        resolve_taken_in       = rtaken;
        resolve_target_in      = rtgt;
        resolve_pred_in        = rpred;
        resolve_pred_target_in = rptgt;
    endtask

    initial begin
        // Vectors: {rv, rpc, taken, target, pred, pred_target, fetch_pc,
        //           flush, pc_branch (same cycle), prediction, target (next cycle)}
        vecs[0]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h0,  32'h100, 1'b1, 32'h80,   1'b1, 32'h80};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 32'h80, 32'h100, 1'b1, 32'h104,  1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h0,  32'h100, 1'b1, 32'h80,   1'b1, 32'h80};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,  32'h140, 1'b0, 32'h0,    1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h140, 1'b1, 32'h200,  1'b0, 32'h0,  32'h100, 1'b1, 32'h200,  1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,  32'h140, 1'b0, 32'h0,    1'b1, 32'h200};
        vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h0,  32'h100, 1'b1, 32'h80,   1'b1, 32'h80};
        vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'h90,   1'b1, 32'h80, 32'h100, 1'b1, 32'h90,   1'b1, 32'h90};
        vecs[8]  = '{1'b1, 32'h100, 1'b1, 32'h90,   1'b1, 32'h90, 32'h100, 1'b0, 32'h0,    1'b1, 32'h90};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 32'h90, 32'h100, 1'b1, 32'h104,  1'b1, 32'h90};
        vecs[10] = '{1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 32'h90, 32'h100, 1'b1, 32'h104,  1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h300, 1'b0, 32'h0,    1'b0, 32'h0,  32'h300, 1'b0, 32'h0,    1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h204, 1'b1, 32'h1000, 1'b0, 32'h0,  32'h204, 1'b1, 32'h1000, 1'b1, 32'h1000};
        vecs[13] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 32'h40, 32'h206, 1'b1, 32'h0,  1'b1, 32'h1000};

        // Reset block: outputs must stay low even with a would-be mispredict present
        rst_in      = 1'b0;
        pc_fetch_in = 32'h100;
        drive_resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_pred",   {31'b0, prediction_out}, 32'h0);
        check("rst_ptgt",   pc_prediction_out,       32'h0);
        check("rst_flush",  {31'b0, flush_out},      32'h0);
        check("rst_branch", pc_branch_out,           32'h0);
        drive_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("post_rst_pred",  {31'b0, prediction_out}, 32'h0);
        check("post_rst_flush", {31'b0, flush_out},      32'h0);
`ifdef BPU_STATS_EN
        check("post_rst_bcnt", branch_count_out,     32'h0);
        check("post_rst_mcnt", mispredict_count_out, 32'h0);
`endif

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_in);
            drive_resolve(vecs[i].rv, vecs[i].rpc, vecs[i].rtaken, vecs[i].rtgt,
                          vecs[i].rpred, vecs[i].rptgt);
            pc_fetch_in = vecs[i].fpc;
            #1;
            check($sformatf("v%0d_flush", i),  {31'b0, flush_out}, {31'b0, vecs[i].eflush});
            check($sformatf("v%0d_branch", i), pc_branch_out,      vecs[i].ebranch);
            if (vecs[i].rv) exp_branches++;
            if (vecs[i].eflush) exp_flushes++;
            @(posedge clk_in);
            #1;
            drive_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            check($sformatf("v%0d_pred", i), {31'b0, prediction_out}, {31'b0, vecs[i].epred});
            check($sformatf("v%0d_ptgt", i), pc_prediction_out,       vecs[i].eptgt);
        end
`ifdef BPU_STATS_EN
        check("tbl_bcnt", branch_count_out,     32'(exp_branches));
        check("tbl_mcnt", mispredict_count_out, 32'(exp_flushes));
`endif

        // Read-during-write: entry 0 holds counter 01 / target 0x90 here
        @(negedge clk_in);
        drive_resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        pc_fetch_in = 32'h100;
        #1;
        check("rdw_pre_pred", {31'b0, prediction_out}, 32'h0);
        check("rdw_pre_ptgt", pc_prediction_out,       32'h0);
        check("rdw_flush",    {31'b0, flush_out},      32'h1);
        exp_branches++;
        exp_flushes++;
        @(posedge clk_in);
        #1;
        drive_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("rdw_post_pred", {31'b0, prediction_out}, 32'h1);
        check("rdw_post_ptgt", pc_prediction_out,       32'h80);

        // Saturation: five correctly predicted taken resolves, then one not-taken
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            drive_resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            #1;
            check($sformatf("sat%0d_flush", k), {31'b0, flush_out}, 32'h0);
            exp_branches++;
        end
        @(negedge clk_in);
        drive_resolve(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        check("sat_nt_branch", pc_branch_out, 32'h104);
        exp_branches++;
        exp_flushes++;
        @(posedge clk_in);
        #1;
        drive_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("sat_nt_pred", {31'b0, prediction_out}, 32'h1);
        check("sat_nt_ptgt", pc_prediction_out,       32'h80);
`ifdef BPU_STATS_EN
        check("sat_bcnt", branch_count_out,     32'(exp_branches));
        check("sat_mcnt", mispredict_count_out, 32'(exp_flushes));
`endif

        // Reset dropped mid-cycle: immediate clear, outputs forced low
        @(posedge clk_in);
        #2;
        drive_resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        rst_in = 1'b0;
        #1;
        check("mid_rst_pred",   {31'b0, prediction_out}, 32'h0);
        check("mid_rst_ptgt",   pc_prediction_out,       32'h0);
        check("mid_rst_flush",  {31'b0, flush_out},      32'h0);
        check("mid_rst_branch", pc_branch_out,           32'h0);
`ifdef BPU_STATS_EN
        check("mid_rst_bcnt", branch_count_out,     32'h0);
        check("mid_rst_mcnt", mispredict_count_out, 32'h0);
`endif
        drive_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("rel_rst_pred", {31'b0, prediction_out}, 32'h0);
        check("rel_rst_ptgt", pc_prediction_out,       32'h0);
        @(posedge clk_in);
        #1;
        check("rel_rst_pred2", {31'b0, prediction_out}, 32'h0);
`ifdef BPU_STATS_EN
        check("rel_rst_bcnt", branch_count_out,     32'h0);
        check("rel_rst_mcnt", mispredict_count_out, 32'h0);
`endif

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bpu.md
# bpu

Branch prediction unit feeding the fetch stage's speculative PC path. Each cycle it looks up the current fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and drives a taken prediction and predicted target. When the execute stage resolves a branch, it detects mispredictions, drives the flush request and corrected PC back to fetch in the same cycle, and trains the table at the next clock edge.

## Interface
- WIDTH, 32, PC and target width in bits
- ENTRIES, 16, number of BTB entries; power of two, minimum 2; IDX = log2(ENTRIES)

- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- pc_fetch_in  input  WIDTH  current fetch PC
- prediction_out  output  1  predict taken for pc_fetch_in
- pc_prediction_out  output  WIDTH  predicted target; 0 when prediction_out=0
- resolve_valid_in  input  1  one branch or jump resolved this cycle; single-cycle pulse per branch
- resolve_pc_in  input  WIDTH  PC of the resolved branch
- resolve_taken_in  input  1  actual outcome
- resolve_target_in  input  WIDTH  actual taken target
- resolve_pred_in  input  1  prediction_out value carried with this branch
- resolve_pred_target_in  input  WIDTH  pc_prediction_out value carried with this branch
- flush_out  output  1  misprediction; fetch must redirect
- pc_branch_out  output  WIDTH  corrected PC; 0 when flush_out=0

## Operation
- Entry state: valid bit, tag = PC[WIDTH-1:IDX+2], target[WIDTH-1:0], 2-bit counter. Index = PC[IDX+1:2]. PC[1:0] ignored.
- Lookup (combinational): hit = valid && tag match. prediction_out = hit && counter[1]. pc_prediction_out = target when prediction_out, else 0.
- Mispredict (combinational, only when resolve_valid_in=1):
  - resolve_taken_in != resolve_pred_in, or
  - both 1 and resolve_target_in != resolve_pred_target_in.
- pc_branch_out = resolve_target_in if resolve_taken_in, else resolve_pc_in + 4 (modulo 2^WIDTH).
- Training on clock edge when resolve_valid_in=1, indexed by resolve_pc_in:
  - Hit: counter +1 if taken (saturating at 11), -1 if not taken (saturating at 00). Target overwritten with resolve_target_in if taken.
  - Miss, taken: allocate/replace entry; valid=1, tag, target, counter=10 (weakly taken).
  - Miss, not taken: no change.
- Reset: all valid bits cleared, all counters set to 01, targets and tags set to 0.

## Timing
- Lookup is 0-cycle: outputs follow pc_fetch_in combinationally.
- flush_out and pc_branch_out are 0-cycle from the resolve inputs, for fetch's redirect mux.
- Training is visible to lookups from the cycle after the resolving edge.
- Read-during-write to the same entry returns pre-update contents.
- No stall input: training depends only on resolve_valid_in. The pipeline suppresses duplicate pulses during stalls.
- Reset asserted mid-operation clears the table immediately. While rst_in=0: prediction_out=0, pc_prediction_out=0, flush_out=0, pc_branch_out=0.
- Lookup and resolve on different or the same entries in one cycle are independent.

## Configuration
- BPU_STATS_EN defined: adds outputs branch_count_out and mispredict_count_out (32 bits each).
  - Counters reset to 0.
  - branch_count_out increments on each resolve_valid_in.
  - mispredict_count_out increments on each flush_out.
  - Both wrap modulo 2^32.
- Undefined: those ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, pc_fetch_in=0x100 -> prediction_out=0, pc_prediction_out=0, flush_out=0.
- Resolve pc=0x100, taken=1, target=0x80, pred=0:
  - Same cycle: flush_out=1, pc_branch_out=0x80.
  - Next cycle, fetch 0x100: prediction_out=1, pc_prediction_out=0x80.
- Continue with resolve pc=0x100, taken=0, pred=1, pred_target=0x80:
  - Same cycle: flush_out=1, pc_branch_out=0x104.
  - Next cycle, fetch 0x100: prediction_out=0 (counter 01).
- Aliasing: train 0x100 taken to 0x80, then fetch 0x140 (same index, different tag) -> prediction_out=0. Resolve 0x140 taken to 0x200 -> entry replaced; fetch 0x100 now misses.
- Target change: 0x100 trained to 0x80; resolve taken=1, target=0x90, pred=1, pred_target=0x80 -> flush_out=1, pc_branch_out=0x90. Next fetch 0x100 -> pc_prediction_out=0x90.
- Saturation and reset:
  - Five taken resolves at 0x100 -> counter 11.
  - One not-taken resolve -> prediction_out stays 1.
  - Drop rst_in mid-cycle -> prediction_out=0 immediately and after release.
  - With BPU_STATS_EN, counts match resolves and flushes, and both read 0 after reset.
